phy_tx_width_gasket: RTL and testbench

Parametrised TX width gasket between the MAC and the PHY TX datapath (8b/10b encoder side). Accepts MAC words of 8, 16 or 32 bits (up to `8*MAX_BYTES`) through a valid/ready handshake and buffers them in a 2-entry word FIFO. Serialises them one symbol per `Bit_Rate_CLK_10` cycle, LSB byte first, with a per-byte K flag. Bus width is latched per word, so width changes never corrupt a word in flight, and back-to-back words stream with no idle gaps.

---
 rtl/phy_tx_width_gasket.sv | 170 +++++++++++++++++
 tb/tb_phy_tx_width_gasket.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_tx_width_gasket.sv
// MAC-to-PHY TX width gasket: 2-entry word FIFO feeding a symbol serializer, LSB byte first.
// Optional sticky Underrun flag when GASKET_UNDERRUN_FLAG_EN is defined.
module phy_tx_width_gasket #(
  parameter int MAX_BYTES = 4,
  parameter int SYM_W     = 8
) (
  input  logic                       Bit_Rate_CLK_10,
  input  logic                       Reset,
  input  logic [5:0]                 DataBusWidth,
  input  logic [SYM_W*MAX_BYTES-1:0] MAC_TX_Data,
  input  logic [MAX_BYTES-1:0]       MAC_TX_DataK,
  input  logic                       MAC_Data_Valid,
  output logic                       MAC_Data_Ready,
  output logic [SYM_W-1:0]           TxData,
  output logic                       TxDataK,
  output logic                       TxValid
`ifdef GASKET_UNDERRUN_FLAG_EN
  ,
  output logic                       Underrun
`endif
);

  localparam int WORD_W = SYM_W * MAX_BYTES;
  localparam int IDX_W  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } state_t;

  logic [WORD_W-1:0]    r_fifo_data [0:1];
  logic [MAX_BYTES-1:0] r_fifo_k    [0:1];
  logic [IDX_W-1:0]     r_fifo_last [0:1];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [1:0]           r_count;

  state_t               r_state;
  logic [IDX_W-1:0]     r_idx;
  logic [WORD_W-1:0]    r_word;
  logic [MAX_BYTES-1:0] r_word_k;
  logic [IDX_W-1:0]     r_last;

  state_t               w_state_next;
  logic [IDX_W-1:0]     w_idx_next;
  logic                 w_push;
  logic                 w_load;
  logic                 w_emit;
  logic                 w_fifo_nonempty;
  logic [IDX_W-1:0]     w_in_last;

  assign MAC_Data_Ready  = !Reset && (r_count < 2'd2);
  assign w_push          = MAC_Data_Valid && MAC_Data_Ready;
  assign w_fifo_nonempty = (r_count != 2'd0);

  // Index of the last byte to emit; unsupported or oversized widths send byte 0 only.
  always_comb begin
    w_in_last = '0;
    if (DataBusWidth == 6'd16 && MAX_BYTES >= 2) begin
      w_in_last = IDX_W'(1);
    end else if (DataBusWidth == 6'd32 && MAX_BYTES >= 4) begin
      w_in_last = IDX_W'(3);
    end
  end

  always_ff @(posedge Bit_Rate_CLK_10) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= MAC_TX_Data;
      r_fifo_k[r_wr_ptr]    <= MAC_TX_DataK;
      r_fifo_last[r_wr_ptr] <= w_in_last;
    end
  end

  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_load) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_load})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_emit       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fifo_nonempty) begin
          w_load       = 1'b1;
          w_idx_next   = '0;
          w_state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        w_emit = 1'b1;
        if (r_idx != r_last) begin
          w_idx_next = r_idx + IDX_W'(1);
        end else if (w_fifo_nonempty) begin
          // Reload on the last byte so consecutive words stream without a gap.
          w_load     = 1'b1;
          w_idx_next = '0;
        end else begin
          w_idx_next   = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_word   <= '0;
      r_word_k <= '0;
      r_last   <= '0;
      TxData   <= '0;
      TxDataK  <= 1'b0;
      TxValid  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      if (w_load) begin
        r_word   <= r_fifo_data[r_rd_ptr];
        r_word_k <= r_fifo_k[r_rd_ptr];
        r_last   <= r_fifo_last[r_rd_ptr];
      end
      TxValid <= w_emit;
      TxData  <= w_emit ? SYM_W'(r_word >> (32'(r_idx) * SYM_W)) : '0;
      TxDataK <= w_emit & 1'(r_word_k >> r_idx);
    end
  end

`ifdef GASKET_UNDERRUN_FLAG_EN
  logic r_sent;

  // Any IDLE cycle after the first emitted symbol is a starvation event.
  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      r_sent   <= 1'b0;
      Underrun <= 1'b0;
    end else begin
      if (w_emit) begin
        r_sent <= 1'b1;
      end
      if (r_state == ST_IDLE && r_sent) begin
        Underrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_phy_tx_width_gasket.sv
// Self-checking bench for phy_tx_width_gasket: directed scenarios plus randomized traffic
// checked against a byte-stream queue model built from accepted words.
module tb_phy_tx_width_gasket;
  localparam int MB = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    width;
  logic [31:0]   data;
  logic [3:0]    dk;
  logic          valid;
  logic          ready;
  logic [7:0]    txd;
  logic          txk;
  logic          txv;
`ifdef GASKET_UNDERRUN_FLAG_EN
  logic          underrun;
`endif

  int checks = 0;
  int errors = 0;
  bit [8:0] exp_q[$];
  bit [8:0] obs_q[$];
  int first_v;
  int last_v;
  int cyc;
  bit last_acc;

  always #5 clk = ~clk;

  phy_tx_width_gasket #(.MAX_BYTES(MB), .SYM_W(SW)) dut (
    .Bit_Rate_CLK_10(clk),
    .Reset(rst),
    .DataBusWidth(width),
    .MAC_TX_Data(data),
    .MAC_TX_DataK(dk),
    .MAC_Data_Valid(valid),
    .MAC_Data_Ready(ready),
    .TxData(txd),
    .TxDataK(txk),
    .TxValid(txv)
`ifdef GASKET_UNDERRUN_FLAG_EN
    ,
    .Underrun(underrun)
`endif
  );

  // Symbols a word contributes, straight from the width rules.
  function automatic int model_bytes(input logic [5:0] w);
    int n;
    case (w)
      6'd8:    n = 1;
      6'd16:   n = 2;
      6'd32:   n = 4;
      default: n = 1;
    endcase
    if (n > MB) n = 1;
    return n;
  endfunction

  task automatic clear_obs();
    exp_q.delete();
    obs_q.delete();
    first_v = -1;
    last_v  = -1;
    cyc     = 0;
  endtask

  // One clock: log the handshake into the model, then capture the outputs.
  task automatic tick();
    last_acc = valid && ready;
    if (last_acc) begin
      for (int b = 0; b < model_bytes(width); b++)
        exp_q.push_back({dk[b], data[b*8 +: 8]});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (txv) begin
      obs_q.push_back({txk, txd});
      if (first_v < 0) first_v = cyc;
      last_v = cyc;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; width = 6'd8; data = '0; dk = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txv !== 1'b0) begin errors++; $display("FAIL reset_txvalid got=%b exp=0", txv); end
    checks++; if (txd !== 8'h00) begin errors++; $display("FAIL reset_txdata got=%h exp=00", txd); end
    checks++; if (txk !== 1'b0) begin errors++; $display("FAIL reset_txk got=%b exp=0", txk); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", ready); end
`ifdef GASKET_UNDERRUN_FLAG_EN
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got=%b exp=1", ready); end
    clear_obs();
    tick();
    checks++; if (txv !== 1'b0) begin errors++; $display("FAIL idle_txvalid got=%b exp=0", txv); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    bit [8:0] exp_tab[4];
    exp_tab = '{9'h1AA, 9'h0BB, 9'h0CC, 9'h0DD};
    clear_obs();
    width = 6'd32; data = 32'hDDCCBBAA; dk = 4'b0001; valid = 1'b1;
    tick();
    valid = 1'b0; data = $urandom; width = 6'($urandom); dk = 4'($urandom);
    repeat (7) tick();
    checks++; if (first_v != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", first_v); end
    checks++; if (obs_q.size() != 4 || last_v != 6) begin
      errors++; $display("FAIL basic_valid_len got=%0d last=%0d exp=4 last=6", obs_q.size(), last_v);
    end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_tab[i]) begin
        errors++; $display("FAIL basic_sym%0d got=%h exp=%h", i, obs_q[i], exp_tab[i]);
      end
    end
    checks++; if (txv !== 1'b0 || txd !== 8'h00 || txk !== 1'b0) begin
      errors++; $display("FAIL basic_return_idle got=%b/%h/%b exp=0/00/0", txv, txd, txk);
    end
    $display("test_basic sym=%0d first=%0d", obs_q.size(), first_v);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words[3];
    int i;
    words = '{32'h0000_2211, 32'h0000_4433, 32'h0000_6655};
    clear_obs();
    width = 6'd16; dk = 4'b0000; valid = 1'b1; i = 0; data = words[0];
    for (int c = 0; c < 10 && i < 3; c++) begin
      tick();
      if (last_acc) i++;
      if (i < 3) data = words[i];
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full got=%b exp=0", ready); end
    valid = 1'b0; data = $urandom;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_free got=%b exp=1", ready); end
    repeat (10) tick();
    checks++; if (obs_q.size() != 6 || last_v - first_v + 1 != 6) begin
      errors++; $display("FAIL b2b_gapless got=%0d span=%0d exp=6", obs_q.size(), last_v - first_v + 1);
    end
    for (int k = 0; k < 6 && k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL b2b_sym%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    $display("test_back_to_back sym=%0d span=%0d", obs_q.size(), last_v - first_v + 1);
  endtask

  task automatic test_width8();
    clear_obs();
    width = 6'd8; valid = 1'b1;
    for (int j = 0; j < 16; j++) begin
      data = {24'($urandom), 8'(j + 1)};
      dk   = 4'($urandom);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL w8_ready%0d got=%b exp=1", j, ready); end
      tick();
    end
    valid = 1'b0;
    repeat (6) tick();
    checks++; if (obs_q.size() != 16 || first_v != 3 || last_v != 18) begin
      errors++; $display("FAIL w8_stream got=%0d first=%0d last=%0d exp=16 first=3 last=18", obs_q.size(), first_v, last_v);
    end
    for (int k = 0; k < 16 && k < obs_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_q[k] || obs_q[k][7:0] != 8'(k + 1)) begin
        errors++; $display("FAIL w8_sym%0d got=%h exp=%h", k, obs_q[k], exp_q[k]);
      end
    end
    $display("test_width8 sym=%0d", obs_q.size());
  endtask

  task automatic test_width_change();
    bit [8:0] exp_tab[6];
    exp_tab = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h0EE, 9'h0DD};
    clear_obs();
    width = 6'd32; data = 32'h0403_0201; dk = 4'b0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    checks++; if (txd !== 8'h02) begin errors++; $display("FAIL wc_byte1 got=%h exp=02", txd); end
    width = 6'd8; data = 32'h0000_00EE; valid = 1'b1;
    tick();
    width = 6'd24; data = 32'hAABB_CCDD;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL wc_ready got=%b exp=1", ready); end
    tick();
    valid = 1'b0; width = 6'd32; data = $urandom;
    repeat (10) tick();
    checks++; if (obs_q.size() != 6 || last_v - first_v + 1 != 6) begin
      errors++; $display("FAIL wc_len got=%0d span=%0d exp=6", obs_q.size(), last_v - first_v + 1);
    end
    for (int k = 0; k < 6 && k < obs_q.size(); k++) begin
      checks++; if (obs_q[k] !== exp_tab[k]) begin
        errors++; $display("FAIL wc_sym%0d got=%h exp=%h", k, obs_q[k], exp_tab[k]);
      end
    end
    $display("test_width_change sym=%0d", obs_q.size());
  endtask

  task automatic test_reset_mid();
    clear_obs();
    width = 6'd32; data = 32'h4433_2211; dk = 4'b0010; valid = 1'b1;
    tick();
    data = 32'h8877_6655;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    checks++; if (txv !== 1'b1 || txd !== 8'h33) begin
      errors++; $display("FAIL rm_byte2 got=%b/%h exp=1/33", txv, txd);
    end
    rst = 1'b1;
    #1;
    checks++; if (txv !== 1'b0 || txd !== 8'h00 || txk !== 1'b0) begin
      errors++; $display("FAIL rm_async_clear got=%b/%h/%b exp=0/00/0", txv, txd, txk);
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rm_ready got=%b exp=0", ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    width = 6'd8; data = 32'h0000_005A; dk = 4'b0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (8) tick();
    checks++; if (obs_q.size() != 1 || first_v != 3) begin
      errors++; $display("FAIL rm_after_len got=%0d first=%0d exp=1 first=3", obs_q.size(), first_v);
    end
    checks++; if (obs_q.size() < 1 || obs_q[0] !== 9'h05A) begin
      errors++; $display("FAIL rm_after_sym got=%h exp=05a", (obs_q.size() > 0) ? obs_q[0] : 9'h1FF);
    end
    $display("test_reset_mid sym=%0d", obs_q.size());
  endtask

  task automatic test_random();
    logic [5:0] wtab[8];
    bit [8:0] e;
    int nsym;
    wtab = '{6'd8, 6'd16, 6'd32, 6'd32, 6'd16, 6'd8, 6'd24, 6'd0};
    clear_obs();
    nsym = 0;
    for (int c = 0; c < 400; c++) begin
      valid = ($urandom % 4) != 0;
      width = wtab[$urandom % 8];
      data  = $urandom;
      dk    = 4'($urandom);
      tick();
      if (txv) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_extra_sym cyc=%0d got=%h exp=none", c, {txk, txd});
        end else begin
          e = exp_q.pop_front();
          nsym++;
          if ({txk, txd} !== e) begin errors++; $display("FAIL rnd_sym cyc=%0d got=%h exp=%h", c, {txk, txd}, e); end
        end
      end else if (txd !== 8'h00 || txk !== 1'b0) begin
        checks++; errors++; $display("FAIL rnd_idle_out cyc=%0d got=%h/%b exp=00/0", c, txd, txk);
      end
    end
    valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      tick();
      if (txv) begin
        e = exp_q.pop_front();
        nsym++;
        checks++; if ({txk, txd} !== e) begin errors++; $display("FAIL rnd_drain_sym got=%h exp=%h", {txk, txd}, e); end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_drain_left got=%0d exp=0", exp_q.size()); end
    repeat (3) tick();
    $display("test_random symbols=%0d", nsym);
  endtask

`ifdef GASKET_UNDERRUN_FLAG_EN
  task automatic test_underrun();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_obs();
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_init got=%b exp=0", underrun); end
    width = 6'd16; data = 32'h0000_BEEF; dk = 4'b0000; valid = 1'b1;
    tick();
    valid = 1'b0;
    repeat (3) tick();
    checks++; if (txd !== 8'hBE || underrun !== 1'b0) begin
      errors++; $display("FAIL ur_byte1 got=%h/%b exp=be/0", txd, underrun);
    end
    tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_rise got=%b exp=1", underrun); end
    repeat (5) tick();
    checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky got=%b exp=1", underrun); end
    rst = 1'b1;
    #1;
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_reset got=%b exp=0", underrun); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("test_underrun done");
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_width8();
    test_width_change();
    test_reset_mid();
    test_random();
`ifdef GASKET_UNDERRUN_FLAG_EN
    test_underrun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
